// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt controller.
package intr_pkg;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned NSRC      = 2;
    localparam int unsigned SRC_TIMER = 0;
    localparam int unsigned SRC_EXT   = 1;

    // All sources enabled out of reset; only the global ie gate is closed.
    localparam logic [NSRC-1:0] MASK_RESET = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// Request, control-unit and PC/stack signals of the interrupt controller.
interface intr_ctrl_if;
    import intr_pkg::*;

    logic              irq_timer;
    logic              irq_ext;
    logic [ADDR_W-1:0] vec0;
    logic [ADDR_W-1:0] vec1;
    logic [ADDR_W-1:0] pc_ret;
    logic              ie_set;
    logic              ie_clr;
    logic              mask_we;
    logic [NSRC-1:0]   mask_wd;
    logic              reti;

    logic              take_intr;
    logic [ADDR_W-1:0] vector;
    logic              push;
    logic [ADDR_W-1:0] push_addr;
    logic              pop;
    logic              in_service;
    logic [NSRC-1:0]   pending;

    // Side that drives requests and decoded instructions.
    modport master (
        output irq_timer, irq_ext, vec0, vec1, pc_ret,
               ie_set, ie_clr, mask_we, mask_wd, reti,
        input  take_intr, vector, push, push_addr, pop, in_service, pending
    );

    // The controller itself.
    modport slave (
        input  irq_timer, irq_ext, vec0, vec1, pc_ret,
               ie_set, ie_clr, mask_we, mask_wd, reti,
        output take_intr, vector, push, push_addr, pop, in_service, pending
    );

endinterface

// File: rtl/edge_rise.sv
// Rising-edge detector: pulse is high in the cycle where d is 1 and was 0 last cycle.
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // One-cycle history of the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/intr_ctrl.sv
// Two-source interrupt controller: edge capture, mask/ie gating, fixed priority
// (timer over external), vector select and return-address push.
// Optional feature macro: INTR_NEST_EN (timer may preempt the external handler).
module intr_ctrl
    import intr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    intr_ctrl_if.slave  bus
);

    state_t          state;
    state_t          state_next;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] pulse;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] pending_clr;
    logic            ie;
    logic            cur_src;
    logic            sel_src;
    logic            reti_ok;
`ifdef INTR_NEST_EN
    logic [1:0]      depth;
    logic            saved_src;
    logic            preempt;
`endif

    edge_rise u_edge_timer (
        .clk   (clk),
        .reset (reset),
        .d     (bus.irq_timer),
        .pulse (pulse[SRC_TIMER])
    );

    edge_rise u_edge_ext (
        .clk   (clk),
        .reset (reset),
        .d     (bus.irq_ext),
        .pulse (pulse[SRC_EXT])
    );

    assign eligible    = pending & mask;
    assign sel_src     = eligible[SRC_TIMER] ? 1'(SRC_TIMER) : 1'(SRC_EXT);
    // A reti coinciding with reset must not pop: the stack is being abandoned.
    assign reti_ok     = bus.reti && (state == ST_SERVICE) && !reset;
    assign pending_clr = (state == ST_ENTER) ? (NSRC'(1) << cur_src) : '0;
`ifdef INTR_NEST_EN
    // Only the external handler at depth 1 can be interrupted, and only by the timer.
    assign preempt = ie && pending[SRC_TIMER] && mask[SRC_TIMER]
                     && (cur_src == 1'(SRC_EXT)) && (depth == 2'd1);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (ie && (|eligible)) begin
                    state_next = ST_ENTER;
                end
            end
            ST_ENTER: begin
                state_next = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (reti_ok) begin
`ifdef INTR_NEST_EN
                    state_next = (depth == 2'd2) ? ST_SERVICE : ST_IDLE;
`else
                    state_next = ST_IDLE;
`endif
                end
`ifdef INTR_NEST_EN
                else if (preempt) begin
                    state_next = ST_ENTER;
                end
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode; vector and return address pass straight through while entering.
    always_comb begin
        bus.take_intr  = 1'b0;
        bus.push       = 1'b0;
        bus.vector     = '0;
        bus.push_addr  = '0;
        bus.pop        = reti_ok;
        bus.in_service = 1'b0;
        bus.pending    = pending;
        case (state)
            ST_ENTER: begin
                bus.take_intr = 1'b1;
                bus.push      = 1'b1;
                bus.vector    = (cur_src == 1'(SRC_EXT)) ? bus.vec1 : bus.vec0;
                bus.push_addr = bus.pc_ret;
            end
            ST_SERVICE: begin
                bus.in_service = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Pending capture (a new edge beats the clear), mask, ie and source tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            mask      <= MASK_RESET;
            ie        <= 1'b0;
            cur_src   <= 1'(SRC_TIMER);
`ifdef INTR_NEST_EN
            depth     <= 2'd0;
            saved_src <= 1'(SRC_TIMER);
`endif
        end else begin
            pending <= (pending & ~pending_clr) | pulse;

            if (bus.mask_we) begin
                mask <= bus.mask_wd;
            end

            if (bus.ie_clr) begin
                ie <= 1'b0;
            end else if (bus.ie_set) begin
                ie <= 1'b1;
            end

            if ((state == ST_IDLE) && (state_next == ST_ENTER)) begin
                cur_src <= sel_src;
            end

`ifdef INTR_NEST_EN
            if ((state == ST_SERVICE) && (state_next == ST_ENTER)) begin
                saved_src <= cur_src;
                cur_src   <= 1'(SRC_TIMER);
            end

            if (state == ST_ENTER) begin
                depth <= (depth == 2'd2) ? 2'd2 : depth + 2'd1;
            end

            if (reti_ok) begin
                if (depth == 2'd2) begin
                    depth   <= 2'd1;
                    cur_src <= saved_src;
                end else begin
                    depth <= 2'd0;
                end
            end
`endif
        end
    end

endmodule
